uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters, 2..8.
REQ-002 SHALL have parameter D_BITS, default 8: UART data bits per byte.
REQ-003 SHALL have parameter MAX_BURST, default 16: maximum bytes per locked burst, 2..256.
REQ-004 SHALL have port i_clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port i_req, input, N_REQ: bit k set means requester k has a byte pending.
REQ-007 SHALL have port i_data, input, N_REQ*D_BITS: requester k byte at bits [k*D_BITS +: D_BITS].
REQ-008 SHALL have port i_lock, input, N_REQ: requester k asks to keep ownership across bytes.
REQ-009 SHALL have port o_ack, input-side handshake output, N_REQ: one-cycle pulse, byte k consumed.
REQ-010 SHALL have port o_tx_start, output, 1: one-cycle start pulse to the UART transmitter.
REQ-011 SHALL have port o_tx_data, output, D_BITS: byte for the transmitter, stable from o_tx_start until i_tx_done.
REQ-012 SHALL have port i_tx_done, input, 1: one-cycle pulse from the transmitter, frame including stop bits finished.
REQ-013 SHALL have port o_owner, output, $clog2(N_REQ): index of the current or last granted requester.
REQ-014 SHALL have port o_busy, output, 1: high while a byte is in flight.

Function
REQ-015 SHALL be a two-state FSM, IDLE and WAIT; all outputs registered.
REQ-016 In IDLE with any i_req bit set and no lock held, the block SHALL grant the first set bit searching upward from ptr, with wrap.
REQ-017 On a grant edge, the block SHALL capture the winner's byte into o_tx_data, set o_owner, and enter WAIT. In the next cycle it SHALL assert o_tx_start=1, o_ack[winner]=1 and o_busy=1.
REQ-018 Latency from i_req rising in IDLE to o_tx_start SHALL be exactly 1 cycle.
REQ-019 o_tx_start and o_ack SHALL each be high for exactly one cycle per byte.
REQ-020 After a non-locked grant, the block SHALL set ptr to (winner+1) mod N_REQ.
REQ-021 In WAIT, i_req, i_data and i_lock SHALL be ignored.
REQ-022 In WAIT, on i_tx_done the block SHALL return to IDLE and o_busy SHALL fall on the next cycle.
REQ-023 i_tx_done in the same cycle as o_tx_start SHALL be ignored.
REQ-024 i_tx_done in IDLE SHALL be ignored.
REQ-025 The minimum spacing between consecutive o_tx_start pulses SHALL be 2 cycles after i_tx_done.
REQ-026 Requesters that are not granted SHALL keep their request pending; no byte SHALL be dropped or duplicated.
REQ-027 With N_REQ requesters all continuously requesting, each SHALL be served once per N_REQ bytes.

Reset
REQ-028 reset_n low SHALL immediately force: state IDLE, ptr=0, o_owner=0, o_tx_data=0, o_tx_start=0, o_ack=0, o_busy=0, lock released, burst count 0.
REQ-029 Reset asserted mid-byte SHALL abort the byte with no o_ack and no further o_tx_start; the transmitter is reset separately.
REQ-030 Reset deassertion SHALL be synchronised internally (two-flop) before the FSM leaves IDLE.

Configuration
REQ-031 Macro UART_TX_ARB_LOCK_EN defined: burst locking SHALL be enabled.
  - On i_tx_done with i_lock[owner]=1 and burst count < MAX_BURST-1: lock held, count+1, ptr unchanged.
  - While locked in IDLE: only the owner may be granted.
  - While locked with owner i_req=0 and i_lock=0: lock released with no grant that cycle; ptr=(owner+1) mod N_REQ.
  - When the count reaches MAX_BURST-1: the lock is released after that byte and ptr advances.
REQ-032 Macro UART_TX_ARB_LOCK_EN undefined: i_lock SHALL be ignored, the lock logic SHALL be absent, and arbitration SHALL be pure per-byte round-robin.

Verification
REQ-033 Single requester: i_req=0001, i_data[0]=0xA5 -> o_tx_start and o_ack[0] 1 cycle later, o_tx_data=0xA5, o_owner=0; i_tx_done 20 cycles later -> o_busy low next cycle.
REQ-034 All four requesting, bytes 0x10..0x13, instant i_tx_done after each start+1 -> o_tx_data order 0x10,0x11,0x12,0x13,0x10.
REQ-035 LOCK_EN, requester 2 with i_lock=1 sending 20 bytes while requester 0 requests -> 16 bytes from 2, then a byte from 0 (ptr wraps from 3 to 0), then 2 resumes.
REQ-036 i_tx_done pulsed in the o_tx_start cycle and again in IDLE -> no state change; the true i_tx_done 10 cycles later completes the byte.
REQ-037 reset_n low 3 cycles after o_tx_start -> all outputs 0 immediately; after release, the pending i_req=0010 is granted with o_owner=1.
REQ-038 LOCK_EN undefined, i_lock=1111 with all requesting -> identical sequence to REQ-034.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from N_REQ byte sources.
// Define UART_TX_ARB_LOCK_EN to let an owner hold the grant for bursts of up to MAX_BURST bytes.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned D_BITS    = 8,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                      i_clk,
  input  logic                      reset_n,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ*D_BITS-1:0]   i_data,
  input  logic [N_REQ-1:0]          i_lock,
  output logic [N_REQ-1:0]          o_ack,
  output logic                      o_tx_start,
  output logic [D_BITS-1:0]         o_tx_data,
  input  logic                      i_tx_done,
  output logic [$clog2(N_REQ)-1:0]  o_owner,
  output logic                      o_busy
);
  localparam int unsigned OW = $clog2(N_REQ);

  typedef enum logic {StIdle, StWait} state_e;

  state_e            state_q, state_d;
  logic [1:0]        sync_q;
  logic [OW-1:0]     ptr_q, ptr_d, owner_q, owner_d;
  logic [D_BITS-1:0] data_q, data_d;
  logic              start_q, start_d, busy_q, busy_d;
  logic [N_REQ-1:0]  ack_q, ack_d;

  logic [N_REQ-1:0]  elig, owner_oh;
  logic              found, release_lock, grant_go, done_go;
  logic [OW-1:0]     win;
  int unsigned       idx;

  // FSM may only leave IDLE once reset release has crossed two flops.
  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], 1'b1};
  end

  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
  end

  // First eligible requester at or above ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && elig[OW'(idx)]) begin
        found = 1'b1;
        win   = OW'(idx);
      end
    end
  end

  // A done pulse coinciding with the start pulse belongs to no frame of ours.
  assign done_go  = (state_q == StWait) && i_tx_done && !start_q;
  assign grant_go = (state_q == StIdle) && sync_q[1] && found && !release_lock;

`ifdef UART_TX_ARB_LOCK_EN
  localparam int unsigned CW = $clog2(MAX_BURST);

  logic          lock_q;
  logic [CW-1:0] burst_q;

  assign elig         = lock_q ? (i_req & owner_oh) : i_req;
  assign release_lock = (state_q == StIdle) && lock_q && !i_req[owner_q] && !i_lock[owner_q];

  // ptr already sits at owner+1 from the burst's first grant, so releases need not touch it.
  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_q  <= 1'b0;
      burst_q <= '0;
    end else if (done_go) begin
      if (i_lock[owner_q] && (burst_q < CW'(MAX_BURST - 1))) begin
        lock_q  <= 1'b1;
        burst_q <= burst_q + 1'b1;
      end else begin
        lock_q  <= 1'b0;
        burst_q <= '0;
      end
    end else if (release_lock) begin
      lock_q  <= 1'b0;
      burst_q <= '0;
    end
  end
`else
  logic unused_lock;
  assign unused_lock  = ^{i_lock, owner_oh, MAX_BURST[0]};
  assign elig         = i_req;
  assign release_lock = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    data_d  = data_q;
    start_d = 1'b0;
    ack_d   = '0;
    busy_d  = busy_q;
    unique case (state_q)
      StIdle: begin
        if (grant_go) begin
          state_d    = StWait;
          owner_d    = win;
          data_d     = i_data[win*D_BITS +: D_BITS];
          start_d    = 1'b1;
          ack_d[win] = 1'b1;
          busy_d     = 1'b1;
          ptr_d      = (win == OW'(N_REQ - 1)) ? '0 : win + 1'b1;
        end
      end
      StWait: begin
        if (done_go) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      data_q  <= data_d;
      start_q <= start_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign o_ack      = ack_q;
  assign o_tx_start = start_q;
  assign o_tx_data  = data_q;
  assign o_owner    = owner_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester byte queues, a round-robin reference
// model and a transmitter stand-in pulsing i_tx_done after a random delay.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int DB = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    req, lock, ack;
  logic [N*DB-1:0] data;
  logic            start, done, busy;
  logic [DB-1:0]   txd;
  logic [1:0]      owner;

  uart_tx_arbiter #(.N_REQ(N), .D_BITS(DB), .MAX_BURST(16)) dut (
    .i_clk     (clk),
    .reset_n   (rst_n),
    .i_req     (req),
    .i_data    (data),
    .i_lock    (lock),
    .o_ack     (ack),
    .o_tx_start(start),
    .o_tx_data (txd),
    .i_tx_done (done),
    .o_owner   (owner),
    .o_busy    (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  logic [7:0] mem [N][64];
  int         head [N];
  int         tail [N];
  logic [N-1:0] lock_want;
  int         m_ptr;
  int         exp_own [$];
  logic [7:0] exp_dat [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input logic [7:0] v);
    mem[k][tail[k] % 64] = v;
    tail[k]++;
  endtask

  task automatic refresh();
    for (int k = 0; k < N; k++) begin
      req[k]            = head[k] != tail[k];
      data[k*DB +: DB]  = (head[k] != tail[k]) ? mem[k][head[k] % 64] : 8'h00;
      lock[k]           = lock_want[k] && (head[k] != tail[k]);
    end
  endtask

  // Requesters consume their front byte on ack and present the next one.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (ack[k]) begin
        check("ack_has_byte", 32'(head[k] != tail[k]), 32'd1);
        if (head[k] != tail[k]) head[k]++;
      end
    end
    refresh();
  endtask

  // Round-robin reference: repeatedly serve the first non-empty queue at or after ptr.
  task automatic plan_rr();
    int cnt [N];
    int pos [N];
    int k;
    bit any;
    for (int i = 0; i < N; i++) begin
      cnt[i] = tail[i] - head[i];
      pos[i] = head[i];
    end
    k   = 0;
    any = 1'b1;
    while (any) begin
      any = 1'b0;
      for (int i = 0; i < N && !any; i++) begin
        k = (m_ptr + i) % N;
        if (cnt[k] > 0) any = 1'b1;
      end
      if (any) begin
        exp_own.push_back(k);
        exp_dat.push_back(mem[k][pos[k] % 64]);
        pos[k]++;
        cnt[k]--;
        m_ptr = (k + 1) % N;
      end
    end
  endtask

  // Serve every expected byte; each start must follow the previous done by exactly 2 cycles.
  task automatic serve(input int dmin, input int dmax);
    int         own;
    logic [7:0] dat;
    int         d;
    while (exp_own.size() > 0) begin
      own = exp_own.pop_front();
      dat = exp_dat.pop_front();
      tick();
      check("tx_start", 32'(start), 32'd1);
      check("ack", 32'(ack), 32'd1 << own);
      check("owner", 32'(owner), 32'(own));
      check("tx_data", 32'(txd), 32'(dat));
      check("busy_rise", 32'(busy), 32'd1);
      tick();
      check("start_pulse", 32'(start), 32'd0);
      check("ack_pulse", 32'(ack), 32'd0);
      d = $urandom_range(dmax, dmin);
      repeat (d - 1) tick();
      check("data_hold", 32'(txd), 32'(dat));
      check("busy_hold", 32'(busy), 32'd1);
      done = 1'b1;
      tick();
      done = 1'b0;
      check("busy_fall", 32'(busy), 32'd0);
      check("idle_no_start", 32'(start), 32'd0);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    done      = 1'b0;
    lock_want = '0;
    m_ptr     = 0;
    for (int k = 0; k < N; k++) begin
      head[k] = 0;
      tail[k] = 0;
    end
    refresh();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    int n;
    req       = '0;
    lock      = '0;
    data      = '0;
    done      = 1'b0;
    lock_want = '0;
    m_ptr     = 0;
    for (int k = 0; k < N; k++) begin
      head[k] = 0;
      tail[k] = 0;
    end
    #1 rst_n = 1'b0;
    #1;
    check("rst_start", 32'(start), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(txd), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) tick();

    // Single requester, long frame.
    push(0, 8'hA5);
    refresh();
    plan_rr();
    serve(20, 20);

    // Done in the start cycle and in IDLE must both be ignored.
    push(1, 8'h3C);
    refresh();
    tick();
    check("d36_start", 32'(start), 32'd1);
    check("d36_owner", 32'(owner), 32'd1);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("d36_busy_after_early_done", 32'(busy), 32'd1);
    repeat (9) tick();
    check("d36_busy_before_done", 32'(busy), 32'd1);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("d36_busy_fall", 32'(busy), 32'd0);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("d36_idle_done_busy", 32'(busy), 32'd0);
    check("d36_idle_done_start", 32'(start), 32'd0);
    check("d36_idle_done_data", 32'(txd), 32'h3C);
    m_ptr = 2;
    push(2, 8'h5A);
    refresh();
    plan_rr();
    serve(1, 3);

    // Four requesters, instant done; lock inputs must not matter without the lock build.
    do_reset();
`ifndef UART_TX_ARB_LOCK_EN
    lock_want = 4'hF;
`endif
    for (int k = 0; k < N; k++) begin
      push(k, 8'h10 + 8'(k));
      push(k, 8'h10 + 8'(k));
    end
    refresh();
    plan_rr();
    serve(1, 1);
    lock_want = '0;

    // Random loads and frame lengths.
    for (int r = 0; r < 8; r++) begin
      n = 0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = $urandom_range(4, 0);
        for (int j = 0; j < c; j++) push(k, 8'($urandom));
        n += c;
      end
      if (n == 0) push($urandom_range(N - 1, 0), 8'($urandom));
      refresh();
      plan_rr();
      serve(1, 5);
    end

    // Reset mid-byte aborts it; the other pending request wins after release.
    do_reset();
    push(0, 8'h77);
    push(1, 8'h88);
    refresh();
    tick();
    check("r37_start", 32'(start), 32'd1);
    check("r37_owner0", 32'(owner), 32'd0);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("r37_start_zero", 32'(start), 32'd0);
    check("r37_ack_zero", 32'(ack), 32'd0);
    check("r37_busy_zero", 32'(busy), 32'd0);
    check("r37_data_zero", 32'(txd), 32'd0);
    check("r37_owner_zero", 32'(owner), 32'd0);
    tick();
    check("r37_held_start", 32'(start), 32'd0);
    rst_n = 1'b1;
    tick();
    check("r37_sync1", 32'(start), 32'd0);
    tick();
    check("r37_sync2", 32'(start), 32'd0);
    m_ptr = 0;
    plan_rr();
    serve(1, 3);

`ifdef UART_TX_ARB_LOCK_EN
    // Requester 2 locks for 20 bytes while requester 0 waits: 16, then 0, then 4 more.
    do_reset();
    push(1, 8'h01);
    refresh();
    plan_rr();
    serve(1, 2);
    lock_want = 4'b0100;
    for (int i = 0; i < 20; i++) push(2, 8'h20 + 8'(i));
    push(0, 8'hE0);
    refresh();
    for (int i = 0; i < 16; i++) begin
      exp_own.push_back(2);
      exp_dat.push_back(8'h20 + 8'(i));
    end
    exp_own.push_back(0);
    exp_dat.push_back(8'hE0);
    for (int i = 16; i < 20; i++) begin
      exp_own.push_back(2);
      exp_dat.push_back(8'h20 + 8'(i));
    end
    serve(1, 3);
    lock_want = '0;
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
